// File: rtl/game_pkg.sv
// Shared game types and helpers used by the dealer and the stage evaluators.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_EFFORT,
    JUDGE,
    DONE
  } state_t;

  localparam logic [6:0] MAX_SCORE = 7'd100;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [6:0] sat_score(input logic [9:0] v);
    if (v > {3'b000, MAX_SCORE}) return MAX_SCORE;
    return v[6:0];
  endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; a zero seed is forced to 8'h01 to avoid lock-up.
module game_lfsr
  import game_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] lfsr_q
);

  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED_EFF;
    else        lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

endmodule

// File: rtl/stage_dealer.sv
// Game master: issues stage challenges, takes player effort via valid/ready,
// samples the evaluator verdict and walks through NUM_STAGES stages.
module stage_dealer
  import game_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned HARD_BASE  = 40,
  parameter int unsigned HARD_STEP  = 15,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       effort_valid,
  input  logic [6:0] effort,
  output logic       effort_ready,
  input  logic       pass_in,
  input  logic [1:0] bonus_in,
  output logic       pass_prev,
  output logic [1:0] bonus_prev,
  output logic [6:0] effort_q,
  output logic [6:0] hard,
  output logic [1:0] luck,
  output logic [2:0] stage_idx,
  output logic       game_over,
  output logic       win
);

  state_t     state, state_next;
  logic [7:0] lfsr_q;
  logic       lfsr_unused;
  logic       last_stage;
  logic       handshake;
  logic [9:0] hard_raw;

  game_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_q (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[7:2];
  assign last_stage  = (stage_idx == 3'(NUM_STAGES - 1));
  assign handshake   = effort_valid && effort_ready;
  assign hard_raw    = 10'(HARD_BASE) + 10'(HARD_STEP) * {7'b0000000, stage_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:        if (start) state_next = ISSUE;
      ISSUE:       state_next = WAIT_EFFORT;
      WAIT_EFFORT: if (handshake) state_next = JUDGE;
      JUDGE:       state_next = (pass_in && !last_stage) ? ISSUE : DONE;
      DONE:        if (start) state_next = ISSUE;
      default:     state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      effort_ready <= 1'b0;
      game_over    <= 1'b0;
      pass_prev    <= 1'b1;
      bonus_prev   <= '0;
      effort_q     <= '0;
      hard         <= '0;
      luck         <= '0;
      stage_idx    <= '0;
      win          <= 1'b0;
    end else begin
      effort_ready <= (state_next == WAIT_EFFORT);
      game_over    <= (state_next == DONE);
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            stage_idx  <= '0;
            pass_prev  <= 1'b1;
            bonus_prev <= '0;
            win        <= 1'b0;
          end
        end
        ISSUE: begin
          hard <= sat_score(hard_raw);
          luck <= lfsr_q[1:0];
        end
        WAIT_EFFORT: begin
          if (handshake) effort_q <= sat_score({3'b000, effort});
        end
        JUDGE: begin
          if (pass_in) begin
            bonus_prev <= bonus_in;
            if (last_stage) begin
              win <= 1'b1;
            end else begin
              pass_prev <= 1'b1;
              stage_idx <= stage_idx + 3'd1;
            end
          end else begin
            win        <= 1'b0;
            pass_prev  <= 1'b0;
            bonus_prev <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_dealer.sv
// Directed bench for stage_dealer: table-driven games plus hand sequences for corner cases.
module tb_stage_dealer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       effort_valid;
  logic [6:0] effort;
  logic       pass_in;
  logic [1:0] bonus_in;

  logic       effort_ready, pass_prev, game_over, win;
  logic [1:0] bonus_prev, luck;
  logic [6:0] effort_q, hard;
  logic [2:0] stage_idx;

  logic       effort_ready2, pass_prev2, game_over2, win2;
  logic [1:0] bonus_prev2, luck2;
  logic [6:0] effort_q2, hard2;
  logic [2:0] stage_idx2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] m_lfsr;
  logic [1:0] exp_luck;

  always #5 clk = ~clk;

  stage_dealer #(.NUM_STAGES(3), .HARD_BASE(40), .HARD_STEP(15), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .effort_valid(effort_valid), .effort(effort),
    .effort_ready(effort_ready), .pass_in(pass_in), .bonus_in(bonus_in),
    .pass_prev(pass_prev), .bonus_prev(bonus_prev), .effort_q(effort_q), .hard(hard),
    .luck(luck), .stage_idx(stage_idx), .game_over(game_over), .win(win)
  );

  stage_dealer #(.NUM_STAGES(3), .HARD_BASE(90), .HARD_STEP(15), .LFSR_SEED(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .effort_valid(effort_valid), .effort(effort),
    .effort_ready(effort_ready2), .pass_in(pass_in), .bonus_in(bonus_in),
    .pass_prev(pass_prev2), .bonus_prev(bonus_prev2), .effort_q(effort_q2), .hard(hard2),
    .luck(luck2), .stage_idx(stage_idx2), .game_over(game_over2), .win(win2)
  );

  // Reference LFSR: taps 8,6,5,4, shifted left every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         new_game;
    logic [6:0] eff;
    logic       pass;
    logic [1:0] bonus;
    int         stage;
    int         exp_hard;
    int         exp_hard2;
    int         exp_bprev;
    int         exp_effq;
    bit         done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rst_n = 1'b0; start = 1'b0; effort_valid = 1'b0; effort = '0;
    pass_in = 1'b0; bonus_in = '0;

    // game 1: all pass with bonus 2
    vecs[0] = '{1, 7'd50,  1, 2'd2, 0, 40, 90,  0, 50,  0};
    vecs[1] = '{0, 7'd120, 1, 2'd2, 1, 55, 100, 2, 100, 0};
    vecs[2] = '{0, 7'd0,   1, 2'd2, 2, 70, 100, 2, 0,   1};
    // game 2: fail at stage 1
    vecs[3] = '{1, 7'd100, 1, 2'd1, 0, 40, 90,  0, 100, 0};
    vecs[4] = '{0, 7'd30,  0, 2'd3, 1, 55, 100, 1, 30,  1};
    // game 3: fail at stage 0
    vecs[5] = '{1, 7'd10,  0, 2'd1, 0, 40, 90,  0, 10,  1};

    #12;
    check("rst_pass_prev", pass_prev, 1);
    check("rst_hard", hard, 0);
    check("rst_stage", stage_idx, 0);
    check("rst_game_over", game_over, 0);
    check("rst_ready", effort_ready, 0);
    check("rst_effort_q", effort_q, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    check("idle_game_over", game_over, 0);

    foreach (vecs[i]) begin
      if (vecs[i].new_game) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_stage", stage_idx, 0);
        check("start_pass_prev", pass_prev, 1);
        check("start_bonus_prev", bonus_prev, 0);
        check("start_game_over", game_over, 0);
      end
      exp_luck = m_lfsr[1:0];
      tick();
      check("wait_hard", hard, vecs[i].exp_hard);
      check("wait_hard_sat", hard2, vecs[i].exp_hard2);
      check("wait_luck", luck, exp_luck);
      check("wait_stage", stage_idx, vecs[i].stage);
      check("wait_bonus_prev", bonus_prev, vecs[i].exp_bprev);
      check("wait_pass_prev", pass_prev, 1);
      check("wait_ready", effort_ready, 1);
      effort = vecs[i].eff; effort_valid = 1'b1;
      pass_in = vecs[i].pass; bonus_in = vecs[i].bonus;
      tick();
      effort_valid = 1'b0;
      check("judge_effort_q", effort_q, vecs[i].exp_effq);
      check("judge_ready", effort_ready, 0);
      tick();
      check("verdict_game_over", game_over, vecs[i].done);
      if (vecs[i].done) begin
        check("done_win", win, vecs[i].pass);
        check("done_stage", stage_idx, vecs[i].stage);
        check("done_pass_prev", pass_prev, vecs[i].pass);
        check("done_bonus_prev", bonus_prev, vecs[i].pass ? vecs[i].bonus : 0);
      end else begin
        check("next_stage", stage_idx, vecs[i].stage + 1);
        check("next_bonus_prev", bonus_prev, vecs[i].bonus);
      end
    end

    // effort_valid during ISSUE must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    effort_valid = 1'b1; effort = 7'd77;
    tick();
    effort_valid = 1'b0;
    check("issue_valid_ignored_ready", effort_ready, 1);
    check("issue_valid_ignored_effq", effort_q, 10);
    check("restart_hard", hard, 40);
    // start and idle cycles in WAIT_EFFORT change nothing
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_ready", effort_ready, 1);
      check("hold_hard", hard, 40);
      check("hold_stage", stage_idx, 0);
      check("hold_game_over", game_over, 0);
    end
    start = 1'b0;
    effort = 7'd120; effort_valid = 1'b1; pass_in = 1'b1; bonus_in = 2'd3;
    tick();
    check("sat_effort_q", effort_q, 100);
    effort = 7'd5;
    tick();
    effort_valid = 1'b0;
    check("judge_valid_ignored_effq", effort_q, 100);
    check("judge_valid_stage", stage_idx, 1);
    tick();
    check("s1_hard", hard, 55);
    check("s1_bonus_prev", bonus_prev, 3);
    effort = 7'd60; effort_valid = 1'b1;
    tick();
    effort_valid = 1'b0;
    check("pre_reset_effq", effort_q, 60);

    // asynchronous reset while in JUDGE
    rst_n = 1'b0;
    #2;
    check("async_rst_hard", hard, 0);
    check("async_rst_stage", stage_idx, 0);
    check("async_rst_effq", effort_q, 0);
    check("async_rst_bonus_prev", bonus_prev, 0);
    check("async_rst_pass_prev", pass_prev, 1);
    check("async_rst_luck", luck, 0);
    check("async_rst_ready", effort_ready, 0);
    tick();
    check("rst_held_game_over", game_over, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle_ready", effort_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_luck = m_lfsr[1:0];
    tick();
    check("post_rst_luck", luck, exp_luck);
    check("post_rst_hard", hard, 40);
    check("post_rst_stage", stage_idx, 0);
    check("post_rst_ready", effort_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1);
  end

endmodule

// File: doc/stage_dealer.md
Name: stage_dealer

Overview:
- Sequential game master that drives the stage evaluators.
- Each stage evaluator judges one stage combinationally. This block:
  - issues each stage challenge (hard, luck, carried pass/bonus);
  - accepts the player's effort through a valid/ready handshake;
  - samples the evaluator's pass/bonus verdict;
  - advances through NUM_STAGES stages until a win or a fail.
- Sits between the player-input source and the stage evaluator chain.

Parameters:
- NUM_STAGES, 3, number of stages per game (1..8).
- HARD_BASE, 40, hard value for stage 0.
- HARD_STEP, 15, hard increment per stage.
- LFSR_SEED, 8'hA5, LFSR reset value. A zero seed is replaced by 8'h01.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a game; accepted only in IDLE or DONE.
- effort_valid  in  1  player effort is valid.
- effort  in  7  player effort, 0..100.
- effort_ready  out  1  dealer can accept effort.
- pass_in  in  1  evaluator verdict for the current stage.
- bonus_in  in  2  evaluator bonus for the current stage.
- pass_prev  out  1  carried pass flag to evaluator.
- bonus_prev  out  2  carried bonus to evaluator.
- effort_q  out  7  latched effort to evaluator.
- hard  out  7  current stage difficulty, 0..100.
- luck  out  2  current stage random luck.
- stage_idx  out  3  current stage number.
- game_over  out  1  high in DONE.
- win  out  1  valid while game_over; 1 means all stages passed.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, lfsr=LFSR_SEED;
  - all outputs 0, except pass_prev=1.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts every clock outside reset, in every state.
- States: IDLE, ISSUE, WAIT_EFFORT, JUDGE, DONE.
- IDLE:
  - start=1 -> stage_idx<=0, pass_prev<=1, bonus_prev<=0, win<=0 -> ISSUE.
  - Otherwise stay.
- ISSUE (exactly 1 cycle):
  - hard <= min(HARD_BASE + HARD_STEP*stage_idx, 100), computed in 10 bits then saturated.
  - luck <= lfsr[1:0].
  - -> WAIT_EFFORT. hard and luck are stable from the first WAIT_EFFORT cycle until the next ISSUE.
- WAIT_EFFORT:
  - effort_ready=1 (registered; asserted only in this state).
  - On effort_valid && effort_ready: effort_q <= min(effort, 100) -> JUDGE.
  - effort_valid outside WAIT_EFFORT is ignored; nothing is buffered.
- JUDGE (exactly 1 cycle):
  - The evaluator sees stable effort_q/hard/luck/pass_prev/bonus_prev. pass_in and bonus_in are sampled at the end of this cycle.
  - pass_in=1 and stage_idx < NUM_STAGES-1 -> bonus_prev<=bonus_in, pass_prev<=1, stage_idx++ -> ISSUE.
  - pass_in=1 and stage_idx == NUM_STAGES-1 -> win<=1, bonus_prev<=bonus_in -> DONE.
  - pass_in=0 -> win<=0, pass_prev<=0, bonus_prev<=0 -> DONE.
- DONE:
  - game_over=1; stage_idx holds the last judged stage.
  - start=1 -> same actions as from IDLE (new game).
- Latency: effort handshake to verdict sample = 1 cycle. Verdict to next hard valid = 2 cycles (ISSUE, then WAIT_EFFORT).
- start in ISSUE/WAIT_EFFORT/JUDGE is ignored.
- Reset mid-game aborts immediately to IDLE; no partial state survives except the LFSR restart at seed.
- stage_idx never wraps; the DONE transition occurs at NUM_STAGES-1.

Decomposition:
- Shared package (game_pkg) holds:
  - state enum;
  - MAX_SCORE=7'd100;
  - LFSR tap constant;
  - a saturate-to-100 function, also used by the evaluators.
- One natural sub-module: game_lfsr (8-bit, seed parameter, always enabled, outputs full state).

Test Plan:
- Reset then start; evaluator model always passes with bonus_in=2 -> hard=40,55,70 in stages 0,1,2; bonus_prev=0,2,2; DONE with win=1, game_over=1, stage_idx=2.
- Stage 1 pass_in=0 -> DONE, win=0, pass_prev=0, bonus_prev=0, stage_idx=1. A later start restarts at stage 0 with hard=40.
- effort=7'd120 sent -> effort_q=100. Hold effort_valid low for 5 cycles -> state stays WAIT_EFFORT, effort_ready=1, hard unchanged.
- Pulse effort_valid during ISSUE/JUDGE and start during WAIT_EFFORT -> both ignored; stage_idx and hard unchanged.
- Reset asserted in JUDGE -> outputs zero asynchronously (pass_prev=1), state IDLE. luck at the next first ISSUE matches the reference LFSR model seeded 8'hA5.
- HARD_BASE=90, HARD_STEP=15 -> stage 1 hard saturates at 100.
